// File: rtl/phase1_scheduler.sv
// Round-robin front-end sharing one combinational phase1 (dot product + sigmoid LUT)
// among NREQ requesters; holds the teta weight register and returns tagged h results.
module phase1_scheduler #(
  parameter int         NREQ   = 4,
  parameter int         IDW    = 2,
  parameter int         SETTLE = 2,
  parameter logic [7:0] THRESH = 8'd128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*64-1:0]   req_x,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 teta_wr,
  input  logic [63:0]          teta_in,
  output logic                 teta_ack,
  output logic [63:0]          p1_x,
  output logic [63:0]          p1_teta,
  input  logic [7:0]           p1_h,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [7:0]           resp_h,
  output logic [IDW-1:0]       resp_id,
  output logic                 resp_class,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          r_state, w_nxt;
  logic [63:0]     r_teta, r_op_x, w_gnt_x;
  logic [7:0]      r_resp_h;
  logic [IDW-1:0]  r_resp_id, r_rr_ptr, w_gnt_id;
  logic            r_resp_valid, r_teta_ack;
  logic [3:0]      r_cnt;
  logic [NREQ-1:0] w_gnt_oh;
  logic            w_accept, w_load;
  int              w_best, w_dist;

  // Distance of each index from rr_ptr+1; the valid index with the smallest distance wins.
  always_comb begin
    w_gnt_oh = '0;
    w_gnt_id = '0;
    w_gnt_x  = '0;
    w_best   = NREQ;
    w_dist   = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = (i + NREQ - 1 - int'(r_rr_ptr)) % NREQ;
      if (req_valid[i] && (w_dist < w_best)) begin
        w_best      = w_dist;
        w_gnt_oh    = '0;
        w_gnt_oh[i] = 1'b1;
        w_gnt_id    = IDW'(i);
        w_gnt_x     = req_x[i*64 +: 64];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  // A weight load takes the whole IDLE cycle, so it pre-empts any request.
  always_comb begin
    w_nxt    = r_state;
    w_accept = 1'b0;
    w_load   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (teta_wr) begin
          w_load = 1'b1;
        end else if (|req_valid) begin
          w_accept = 1'b1;
          w_nxt    = WAIT;
        end
      end
      WAIT:    if (r_cnt == 4'd0) w_nxt = RESP;
      RESP:    if (resp_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_teta       <= '0;
      r_op_x       <= '0;
      r_resp_h     <= '0;
      r_resp_id    <= '0;
      r_resp_valid <= 1'b0;
      r_teta_ack   <= 1'b0;
      r_rr_ptr     <= IDW'(NREQ - 1);
      r_cnt        <= '0;
    end else begin
      r_teta_ack <= w_load;
      if (w_load) r_teta <= teta_in;
      if (w_accept) begin
        r_op_x    <= w_gnt_x;
        r_resp_id <= w_gnt_id;
        r_rr_ptr  <= w_gnt_id;
        r_cnt     <= 4'(SETTLE - 1);
      end
      if (r_state == WAIT) begin
        if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end else begin
          r_resp_h     <= p1_h;
          r_resp_valid <= 1'b1;
        end
      end
      if ((r_state == RESP) && resp_ready) r_resp_valid <= 1'b0;
    end
  end

  assign req_ready  = w_accept ? w_gnt_oh : '0;
  assign teta_ack   = r_teta_ack;
  assign p1_x       = r_op_x;
  assign p1_teta    = r_teta;
  assign resp_valid = r_resp_valid;
  assign resp_h     = r_resp_h;
  assign resp_id    = r_resp_id;
  assign resp_class = (r_resp_h >= THRESH);
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_phase1_scheduler.sv
// Bench for phase1_scheduler: directed vector table, hand sequences for corner cases,
// then randomized traffic against a timestamp-based reference model.
module tb_phase1_scheduler;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int SETTLE = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ*64-1:0] req_x;
  logic [NREQ-1:0]  req_ready;
  logic             teta_wr;
  logic [63:0]      teta_in;
  logic             teta_ack;
  logic [63:0]      p1_x, p1_teta;
  logic [7:0]       p1_h;
  logic             resp_valid, resp_ready;
  logic [7:0]       resp_h;
  logic [IDW-1:0]   resp_id;
  logic             resp_class, busy;

  logic             use_ovr;
  logic [7:0]       ovr_h;
  int               n_chk = 0;
  int               n_fail = 0;

  always #5 clk = ~clk;

  // Stand-in for the combinational phase1 block.
  function automatic logic [7:0] f_p1(input logic [63:0] x, input logic [63:0] t);
    int s;
    s = 0;
    for (int i = 0; i < 8; i++) s += int'(x[8*i +: 8]) * int'(t[8*i +: 8]);
    return s[15:8];
  endfunction

  assign p1_h = use_ovr ? ovr_h : f_p1(p1_x, p1_teta);

  phase1_scheduler #(.NREQ(NREQ), .IDW(IDW), .SETTLE(SETTLE), .THRESH(8'd128)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .teta_wr(teta_wr), .teta_in(teta_in), .teta_ack(teta_ack), .p1_x(p1_x), .p1_teta(p1_teta),
    .p1_h(p1_h), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_h(resp_h),
    .resp_id(resp_id), .resp_class(resp_class), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  rv;
    logic        tw;
    logic [63:0] ti;
    logic        rr;
    logic [3:0]  e_rdy;
    logic        e_vld;
    logic        e_busy;
    logic        e_ack;
    logic [63:0] e_x;
    logic [63:0] e_t;
    logic [7:0]  e_h;
    logic [1:0]  e_id;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] rv, input logic tw, input logic [63:0] ti,
                              input logic rr, input logic [3:0] e_rdy, input logic e_vld,
                              input logic e_busy, input logic e_ack, input logic [63:0] e_x,
                              input logic [63:0] e_t, input logic [7:0] e_h, input logic [1:0] e_id);
    vec_t v;
    v.rv = rv; v.tw = tw; v.ti = ti; v.rr = rr; v.e_rdy = e_rdy; v.e_vld = e_vld;
    v.e_busy = e_busy; v.e_ack = e_ack; v.e_x = e_x; v.e_t = e_t; v.e_h = e_h; v.e_id = e_id;
    return v;
  endfunction

  localparam logic [63:0] T  = 64'h0102030405060708;
  localparam logic [63:0] D  = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] X0 = 64'h00000000000000A5;
  localparam logic [63:0] X1 = 64'h0000000000000022;
  localparam logic [63:0] X2 = 64'h0000000000000011;
  localparam logic [63:0] X3 = 64'h0000000000000033;

  vec_t tbl[21];

  // reference model state (random phase)
  logic        m_infl, m_ack, m_evld;
  int          m_acc, m_last, m_id, cyc, m_g;
  logic [63:0] m_x, m_teta;
  logic [7:0]  m_last_h, m_eh;
  logic [3:0]  m_rdy;

  initial begin
    int n, prev, gid, last_g;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    rst_n = 1'b0; req_valid = '0; teta_wr = 1'b0; teta_in = '0; resp_ready = 1'b0;
    use_ovr = 1'b1; ovr_h = 8'hA0;
    req_x = '0;
    req_x[0*64 +: 64] = X0; req_x[1*64 +: 64] = X1;
    req_x[2*64 +: 64] = X2; req_x[3*64 +: 64] = X3;

    tbl[0]  = mk(4'b0000, 1'b1, T, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0, 2'd0);
    tbl[1]  = mk(4'b0000, 1'b0, 0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 64'h0, T, 8'h0, 2'd0);
    tbl[2]  = mk(4'b0100, 1'b0, 0, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 64'h0, T, 8'h0, 2'd0);
    tbl[3]  = mk(4'b0000, 1'b0, 0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, X2, T, 8'h0, 2'd0);
    tbl[4]  = tbl[3];
    for (int i = 5; i < 15; i++)
      tbl[i] = mk(4'b0001, (i % 2 == 1), D, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, X2, T, 8'hA0, 2'd2);
    tbl[15] = mk(4'b0001, 1'b0, 0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, X2, T, 8'hA0, 2'd2);
    tbl[16] = mk(4'b0001, 1'b0, 0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, X2, T, 8'h0, 2'd0);
    tbl[17] = mk(4'b0000, 1'b0, 0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, X0, T, 8'h0, 2'd0);
    tbl[18] = tbl[17];
    tbl[19] = mk(4'b0000, 1'b0, 0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, X0, T, 8'hA0, 2'd0);
    tbl[20] = mk(4'b0000, 1'b0, 0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, X0, T, 8'h0, 2'd0);

    // reset state
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_teta", p1_teta, 0);
    chk("rst_x", p1_x, 0);
    chk("rst_h", resp_h, 0);
    chk("rst_id", resp_id, 0);
    chk("rst_ack", teta_ack, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed vector table
    for (int i = 0; i < 21; i++) begin
      req_valid = tbl[i].rv; teta_wr = tbl[i].tw; teta_in = tbl[i].ti; resp_ready = tbl[i].rr;
      #1;
      chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_valid", i), resp_valid, tbl[i].e_vld);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_ack", i), teta_ack, tbl[i].e_ack);
      chk($sformatf("tbl%0d_p1x", i), p1_x, tbl[i].e_x);
      chk($sformatf("tbl%0d_p1teta", i), p1_teta, tbl[i].e_t);
      if (tbl[i].e_vld) begin
        chk($sformatf("tbl%0d_h", i), resp_h, tbl[i].e_h);
        chk($sformatf("tbl%0d_id", i), resp_id, tbl[i].e_id);
        chk($sformatf("tbl%0d_class", i), resp_class, tbl[i].e_h >= 8'd128);
      end
      @(negedge clk);
    end
    use_ovr = 1'b0;

    // teta_wr and request in the same IDLE cycle
    teta_wr = 1'b1; teta_in = 64'h5555AAAA5555AAAA; req_valid = 4'b0010; resp_ready = 1'b1;
    #1; chk("simul_ready0", req_ready, 4'b0000);
    @(negedge clk);
    teta_wr = 1'b0;
    #1;
    chk("simul_ack", teta_ack, 1);
    chk("simul_teta", p1_teta, 64'h5555AAAA5555AAAA);
    chk("simul_ready1", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("simul_resp_valid", resp_valid, 1);
    chk("simul_resp_id", resp_id, 1);
    chk("simul_resp_h", resp_h, f_p1(X1, 64'h5555AAAA5555AAAA));
    @(negedge clk);
    #1; chk("simul_idle", busy, 0);

    // reset while in WAIT
    req_valid = 4'b0001;
    #1; chk("rw_accept", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    #2; rst_n = 1'b0;
    #1;
    chk("rw_resp_valid", resp_valid, 0);
    chk("rw_teta", p1_teta, 0);
    chk("rw_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1; chk("rw_no_resp", resp_valid, 0);
      @(negedge clk);
    end

    // all requesters valid: round-robin order and spacing
    req_valid = 4'b1111; resp_ready = 1'b1;
    n = 0; prev = 0; last_g = 0;
    for (int c = 0; c < 60 && n < 5; c++) begin
      #1;
      if (req_ready != '0) begin
        gid = 0;
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) gid = k;
        chk("rr_order", gid, exp_order[n]);
        if (n > 0) chk("rr_gap", c - prev, SETTLE + 2);
        prev = c; last_g = gid; n++;
      end
      if (resp_valid && resp_ready) chk("rr_resp_id", resp_id, last_g);
      @(negedge clk);
    end
    if (n < 5) chk("rr_timeout_grants", n, 5);
    req_valid = '0;
    for (int c = 0; c < 6; c++) @(negedge clk);

    // randomized traffic against the reference model
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_infl = 0; m_ack = 0; m_acc = 0; m_last = NREQ - 1; m_id = 0; cyc = 0;
    m_x = '0; m_teta = '0; m_last_h = '0;
    for (int it = 0; it < 1500; it++) begin
      req_valid  = 4'($urandom);
      teta_wr    = ($urandom_range(0, 7) == 0);
      teta_in    = {$urandom, $urandom};
      resp_ready = 1'($urandom_range(0, 1));
      for (int k = 0; k < NREQ; k++) req_x[k*64 +: 64] = {$urandom, $urandom};
      #1;
      m_rdy = '0; m_g = -1;
      if (!m_infl && !teta_wr && (req_valid != '0)) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (m_g < 0 && req_valid[(m_last + k) % NREQ]) m_g = (m_last + k) % NREQ;
        end
        m_rdy[m_g] = 1'b1;
      end
      m_evld = m_infl && (cyc >= m_acc + SETTLE);
      m_eh   = m_evld ? f_p1(m_x, m_teta) : m_last_h;
      chk("rnd_ready", req_ready, m_rdy);
      chk("rnd_valid", resp_valid, m_evld);
      chk("rnd_busy", busy, m_infl);
      chk("rnd_ack", teta_ack, m_ack);
      chk("rnd_p1x", p1_x, m_x);
      chk("rnd_p1teta", p1_teta, m_teta);
      chk("rnd_h", resp_h, m_eh);
      chk("rnd_id", resp_id, m_id);
      chk("rnd_class", resp_class, m_eh >= 8'd128);
      m_ack = !m_infl && teta_wr;
      if (m_ack) m_teta = teta_in;
      if (m_g >= 0) begin
        m_infl = 1; m_acc = cyc + 1; m_x = req_x[m_g*64 +: 64]; m_id = m_g; m_last = m_g;
      end else if (m_evld && resp_ready) begin
        m_infl = 0; m_last_h = m_eh;
      end
      cyc++;
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/phase1_scheduler.md
Name: phase1_scheduler

Overview:
- Sequential front-end that shares one combinational phase1 instance (x · teta dot product followed by sigmoid LUT, 8-bit h) among NREQ requesters.
- Holds the weight vector teta in a register that software loads through a write port.
- Arbitrates requests round-robin, registers the winning x, waits SETTLE cycles for the combinational path to settle, captures h, and returns it tagged with the requester id.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of resp_id; must satisfy 2^IDW >= NREQ
- SETTLE, 2, cycles the phase1 operands are held before h is sampled (1..15)
- THRESH, 8'd128, decision threshold for resp_class

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request
- req_x  in  NREQ*64  per-requester feature vector; slice i is bits [64*i+63:64*i]
- req_ready  out  NREQ  one-hot accept strobe, combinational
- teta_wr  in  1  load strobe for the weight register
- teta_in  in  64  new weight vector
- teta_ack  out  1  one-cycle pulse on the cycle after a successful load
- p1_x  out  64  operand to phase1 x
- p1_teta  out  64  operand to phase1 teta
- p1_h  in  8  result from phase1 h
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_h  out  8  captured h
- resp_id  out  IDW  index of the served requester
- resp_class  out  1  resp_h >= THRESH
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; teta_reg=0; op_x=0; resp_h=0; resp_id=0; resp_valid=0; teta_ack=0; rr_ptr=NREQ-1, so req 0 has first priority.
- p1_x=op_x and p1_teta=teta_reg, both driven straight from registers.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If teta_wr=1: teta_reg<=teta_in; teta_ack=1 next cycle; no grant this cycle; req_ready=0. teta_wr wins over any simultaneous request.
  - Else, if any req_valid: grant the first valid index starting at rr_ptr+1 mod NREQ. req_ready[g]=1 in that cycle only.
  - At the edge: op_x<=req_x[g]; resp_id<=g; rr_ptr<=g; cnt<=SETTLE-1; go to WAIT.
- WAIT:
  - If cnt!=0, cnt decrements.
  - If cnt==0: resp_h<=p1_h; resp_valid<=1; go to RESP.
  - h is therefore sampled at the SETTLE-th edge after the accept edge, and resp_valid is visible SETTLE cycles after acceptance.
- RESP:
  - resp_valid, resp_h and resp_id hold stable until resp_valid&&resp_ready at an edge.
  - On that edge: resp_valid<=0; go to IDLE.
  - The next grant is possible at the earliest in the following cycle. Minimum request-to-request spacing is SETTLE+2 cycles.
- In WAIT and RESP: req_ready=0 for all requesters; teta_wr is ignored with no ack, so software must check busy=0 or wait for teta_ack. op_x and teta_reg stay constant, so p1_h stays stable during sampling.
- resp_class is combinational on resp_h and compares unsigned.
- Requesters may drop req_valid without being granted; no requests are queued.
- Reset mid-operation: the in-flight request is discarded with no response, and teta returns to 0.
- A req_valid bit for an index >= NREQ cannot exist; resp_id upper codes are never produced.

Test Plan:
- Reset, then teta_wr=1 with teta_in=64'h0102030405060708 in IDLE -> teta_ack=1 the next cycle; p1_teta=64'h0102030405060708; busy stays 0.
- SETTLE=2, req_valid=4'b0100, x=64'h11, bench phase1 model returns p1_h=8'hA0 -> req_ready=4'b0100 for 1 cycle; p1_x=64'h11; resp_valid rises 2 cycles after accept with resp_h=8'hA0, resp_id=2, resp_class=1.
- All four requesters held valid with resp_ready=1 -> grant order 0,1,2,3,0; each response carries the matching resp_id; gap between accepts is 4 cycles.
- resp_ready=0 for 10 cycles in RESP, with req_valid=4'b0001 and teta_wr=1 pulsed -> resp_h, resp_id and resp_valid stable; req_ready=0; no teta_ack and teta unchanged. After resp_ready=1, request 0 is accepted in the cycle after the response handshake.
- teta_wr=1 and req_valid=4'b0010 in the same IDLE cycle -> teta loaded, req_ready=0; request 1 granted the next cycle.
- rst_n driven low while in WAIT -> resp_valid=0 immediately; p1_teta=0; no response appears afterwards; the first grant after reset goes to req 0 when all are valid.
